// File: rtl/mux1_8x1_sync.sv
// ---------------------------------------------------------------------------
// mux1_8x1_sync
//
// Single-bit 8-to-1 multiplexer, used as a building block for the wider
// datapath mux trees. Y is the purely combinational selection I[S]. YR is a
// registered copy of Y for pipelined consumers.
//
// Parameters:
//   RESET_VAL  value loaded into YR while RST is high
//
// Ports:
//   CLK     in   1  system clock, YR updates on the rising edge
//   RST     in   1  synchronous active-high reset, affects YR only
//   I0..I7  in   1  data inputs, Ik is selected when S == k
//   S       in   3  select, S[2] is the MSB
//   HOLD    in   1  (only with MUX1_8X1_HOLD_EN) freeze YR on non-reset edges
//   Y       out  1  combinational selected input
//   YR      out  1  Y registered on CLK
//
// Build option:
//   MUX1_8X1_HOLD_EN  when defined, adds the HOLD input. On an edge with
//                     RST=0 and HOLD=1, YR keeps its value. RST has priority
//                     over HOLD. Y is never affected by HOLD.
// ---------------------------------------------------------------------------
module mux1_8x1_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I0,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  input  logic       I4,
  input  logic       I5,
  input  logic       I6,
  input  logic       I7,
  input  logic [2:0] S,
`ifdef MUX1_8X1_HOLD_EN
  input  logic       HOLD,
`endif
  output logic       Y,
  output logic       YR
);

  // 2:1 mux that yields X for an unknown select instead of silently falling
  // through to one input; synthesis treats the X as a don't-care.
  function automatic logic mux2(input logic sel, input logic a0, input logic a1);
    logic r;
    case (sel)
      1'b0:    r = a0;
      1'b1:    r = a1;
      default: r = 1'bx;
    endcase
    return r;
  endfunction

  // Binary tree: S[0] picks within pairs, S[1] within quads, S[2] between
  // the two halves.
  logic [3:0] pair_y;
  logic [1:0] quad_y;

  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    pair_y    = '0;
    quad_y    = '0;
    pair_y[0] = mux2(S[0], I0, I1);
    pair_y[1] = mux2(S[0], I2, I3);
    pair_y[2] = mux2(S[0], I4, I5);
    pair_y[3] = mux2(S[0], I6, I7);
    quad_y[0] = mux2(S[1], pair_y[0], pair_y[1]);
    quad_y[1] = mux2(S[1], pair_y[2], pair_y[3]);
    Y         = mux2(S[2], quad_y[0], quad_y[1]);
  end

  // Registered copy. Reset is synchronous and touches YR only; Y above has
  // no clock or reset dependence.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (RST) begin
      YR <= RESET_VAL;
    end
`ifdef MUX1_8X1_HOLD_EN
    else if (!HOLD) begin
      YR <= Y;
    end
`else
    else begin
      YR <= Y;
    end
`endif
  end

endmodule

// File: tb/tb_mux1_8x1_sync.sv
// ---------------------------------------------------------------------------
// tb_mux1_8x1_sync
//
// Directed bench for mux1_8x1_sync. The stimulus thread drives inputs and
// pushes the hand-computed expected value of Y or YR into a queue, then
// pulses a strobe; a separate monitor pops one entry per strobe and compares
// it with the DUT. Define MUX1_8X1_HOLD_EN for both bench and RTL to cover
// the HOLD input.
// ---------------------------------------------------------------------------
module tb_mux1_8x1_sync;

  typedef struct {
    string name;
    bit    is_reg;   // 1: compare YR, 0: compare Y
    logic  exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i   = '0;   // i[k] drives Ik
  logic [2:0] s   = '0;
`ifdef MUX1_8X1_HOLD_EN
  logic       hold = 1'b0;
`endif
  logic       y;
  logic       yr;

  exp_t sb[$];
  logic strobe = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mux1_8x1_sync #(.RESET_VAL(1'b0)) dut (
    .CLK (clk),
    .RST (rst),
    .I0  (i[0]),
    .I1  (i[1]),
    .I2  (i[2]),
    .I3  (i[3]),
    .I4  (i[4]),
    .I5  (i[5]),
    .I6  (i[6]),
    .I7  (i[7]),
    .S   (s),
`ifdef MUX1_8X1_HOLD_EN
    .HOLD(hold),
`endif
    .Y   (y),
    .YR  (yr)
  );

  always #5 clk = ~clk;   // rising edges at 5, 15, 25, ...

  // Monitor: one scoreboard entry per strobe.
  initial begin
    forever begin
      @(strobe);
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL scoreboard_underflow: strobe with no expected entry");
      end else begin
        exp_t e;
        logic act;
        e   = sb.pop_front();
        act = e.is_reg ? yr : y;
        tests_run++;
        if (act !== e.exp) begin
          tests_failed++;
          $display("FAIL %s: %s got %b, expected %b", e.name,
                   e.is_reg ? "YR" : "Y", act, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input bit is_reg, input logic exp);
    exp_t e;
    e.name   = name;
    e.is_reg = is_reg;
    e.exp    = exp;
    sb.push_back(e);
    strobe = ~strobe;
    #1;   // let the monitor sample before anything else changes
  endtask

  // Check YR after the next rising edge, sampled on the following falling edge.
  task automatic edge_expect_yr(input string name, input logic exp);
    @(posedge clk);
    @(negedge clk);
    expect_out(name, 1'b1, exp);
  endtask

  // Hand-computed sweep results, index = S.
  logic [7:0] sweep_a_exp;
  logic [7:0] sweep_b_exp;

  initial begin
    // I0..I7 = 1,0,1,0,1,0,1,0 -> Y for S=0..7 = 1,0,1,0,1,0,1,0
    sweep_a_exp = 8'b0101_0101;
    // I0..I7 = 0,1,0,1,0,1,0,1 -> Y for S=0..7 = 0,1,0,1,0,1,0,1
    sweep_b_exp = 8'b1010_1010;

    // ---- Sweep with alternating pattern ---------------------------------
    i = 8'b0101_0101;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #1;
      expect_out($sformatf("sweep_a_s%0d", k), 1'b0, sweep_a_exp[k]);
      #3;
    end

    // ---- Sweep with inverted pattern ------------------------------------
    i = 8'b1010_1010;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #1;
      expect_out($sformatf("sweep_b_s%0d", k), 1'b0, sweep_b_exp[k]);
      #3;
    end

    // ---- Selected vs non-selected inputs --------------------------------
    s = 3'b101; i = 8'b0000_0000; #1;
    expect_out("sel5_all_zero", 1'b0, 1'b0);
    i[5] = 1'b1; #1;
    expect_out("sel5_i5_set", 1'b0, 1'b1);
    i[4] = 1'b1; i[6] = 1'b1; #1;
    expect_out("sel5_neighbours_set", 1'b0, 1'b1);
    i = 8'b1101_1111; #1;   // only I5 low
    expect_out("sel5_only_i5_low", 1'b0, 1'b0);

    // ---- Reset for two edges with Y=1 -----------------------------------
    @(negedge clk);
    s = 3'b101; i = 8'b0010_0000; rst = 1'b1;
    #1;
    expect_out("rst_y_unaffected", 1'b0, 1'b1);
    edge_expect_yr("rst_edge1", 1'b0);
    edge_expect_yr("rst_edge2", 1'b0);
    expect_out("rst_y_still_1", 1'b0, 1'b1);

    // Release with S=010, I2=1 -> YR follows after one edge
    @(negedge clk);
    rst = 1'b0; s = 3'b010; i = 8'b0000_0100;
    edge_expect_yr("rst_release", 1'b1);

    // ---- Mid-stream reset pulse -----------------------------------------
    @(negedge clk);
    s = 3'b011; i = 8'b0000_1000;
    edge_expect_yr("mid_track", 1'b1);
    rst = 1'b1;
    edge_expect_yr("mid_rst_edge", 1'b0);
    expect_out("mid_rst_y", 1'b0, 1'b1);
    rst = 1'b0;
    edge_expect_yr("mid_resume", 1'b1);
    expect_out("mid_resume_y", 1'b0, 1'b1);

    // ---- YR tracks a falling Y with no reset ----------------------------
    i = 8'b0000_0000;
    edge_expect_yr("track_low", 1'b0);
    i = 8'b0000_1000;
    edge_expect_yr("track_high", 1'b1);

`ifdef MUX1_8X1_HOLD_EN
    // ---- HOLD freezes YR, Y keeps tracking ------------------------------
    hold = 1'b1; s = 3'b000; i = 8'b0000_0000;
    #1;
    expect_out("hold_y_follows", 1'b0, 1'b0);
    edge_expect_yr("hold_edge1", 1'b1);
    edge_expect_yr("hold_edge2", 1'b1);
    hold = 1'b0;
    edge_expect_yr("hold_release", 1'b0);
    // RST wins over HOLD
    i = 8'b0000_0001;
    edge_expect_yr("hold_reload", 1'b1);
    hold = 1'b1; rst = 1'b1;
    edge_expect_yr("hold_rst_priority", 1'b0);
    rst = 1'b0; hold = 1'b0;
    edge_expect_yr("hold_rst_resume", 1'b1);
`endif

    // Drain the scoreboard with a bound.
    for (int k = 0; k < 100 && sb.size() != 0; k++) #1;
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux1_8x1_sync.md
Name: mux1_8x1_sync

Overview:
- Single-bit 8-to-1 multiplexer with a 3-bit select, building block for the datapath's wider mux trees.
- Provides a purely combinational output Y, plus a registered copy YR with synchronous reset for pipelined consumers.
- One clock domain.

Parameters:
- RESET_VAL, 1'b0, value loaded into YR on reset.

Ports:
- CLK  input  1  system clock; YR updates on rising edge.
- RST  input  1  synchronous, active-high reset; affects YR only.
- I0  input  1  data input, selected when S=3'b000.
- I1  input  1  data input, selected when S=3'b001.
- I2  input  1  data input, selected when S=3'b010.
- I3  input  1  data input, selected when S=3'b011.
- I4  input  1  data input, selected when S=3'b100.
- I5  input  1  data input, selected when S=3'b101.
- I6  input  1  data input, selected when S=3'b110.
- I7  input  1  data input, selected when S=3'b111.
- S  input  3  select; S[2] is MSB.
- Y  output  1  combinational selected input.
- YR  output  1  registered Y.

Behaviour:
- Y = I[S] combinationally, zero-cycle latency.
  - Any change on S or on the selected input propagates to Y in the same time step, with no clock dependence.
  - Y is unaffected by RST.
- Changes on non-selected inputs never disturb Y (no glitch-free guarantee required beyond functional correctness).
- Y is structurally a binary tree of 2:1 muxes:
  - S[0] selects within pairs.
  - S[1] selects within quads.
  - S[2] selects between halves.
- S containing X/Z: Y is X. Y must not default to any input.
- YR, rising edge of CLK:
  - If RST=1: YR <= RESET_VAL.
  - Otherwise: YR <= Y.
  - One-cycle latency from S/I change to YR.
- Reset:
  - Reset mid-operation overrides the data path for that edge.
  - Release of RST resumes tracking on the next edge.
- YR holds its value between edges. YR is X before the first clock edge, until reset.
- No state machine, no handshake.

Optional Feature:
- Macro: MUX1_8X1_HOLD_EN.
- Defined:
  - Adds input HOLD (1 bit).
  - On a rising edge with RST=0 and HOLD=1, YR retains its value.
  - RST has priority over HOLD.
  - Y is unaffected by HOLD.
- Undefined:
  - No HOLD port.
  - YR loads Y on every non-reset edge.

Test Plan:
- Inputs I0..I7 = 1,0,1,0,1,0,1,0; step S from 000 to 111, one value every 5 time units -> Y = 1,0,1,0,1,0,1,0, each valid immediately after the S change.
- Inputs I0..I7 = 0,1,0,1,0,1,0,1 (inverted pattern); sweep S from 000 to 111 -> Y = 0,1,0,1,0,1,0,1.
- S=101, all inputs 0; toggle I5 to 1 -> Y=1. Then toggle I4 and I6 -> Y stays 1.
- RST=1 for two edges, with Y=1 -> YR=0. Release RST with S=010 and I2=1 -> YR=1 after one edge.
- S=011, I3=1, then assert RST mid-stream for one edge -> YR=0 on that edge and back to 1 on the next. Y stays 1 throughout.
- With MUX1_8X1_HOLD_EN defined, YR=1, HOLD=1, then change to S=000 with I0=0 -> YR stays 1 while Y=0. Deassert HOLD -> YR=0 on the next edge.
